// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed multiply/divide, WIDTH+1 cycles, own HI/LO registers
// Ports:
//   clock        rising-edge clock
//   reset        synchronous active-low reset
//   md_op[1:0]   00 none, 01 signed mult, 10 signed div, 11 ignored; sampled only when idle
//   a, b         operands (rs, rt), sampled with md_op
//   hi, lo       product high/low, or remainder/quotient
//   busy         operation in flight
//   done         one-cycle pulse when hi/lo are updated or a zero divisor is seen
//   div0         one-cycle pulse with done on a divide by zero
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       md_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div0
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t state_q, state_d;
    // acc upper WIDTH+1 bits: partial product (with carry) or remainder;
    // acc lower WIDTH bits: multiplier being shifted out or quotient being shifted in
    logic [2*WIDTH:0]   acc_q, acc_d;
    // mag holds the multiplicand for mult and the divisor magnitude for div
    logic [WIDTH-1:0]   mag_q, mag_d, hi_q, hi_d, lo_q, lo_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               div_q, div_d, sign_q, sign_d, rsign_q, rsign_d;
    logic               done_q, done_d, div0_q, div0_d;
    logic [WIDTH-1:0]   abs_a, abs_b, quot, rem;
    logic [WIDTH:0]     sum, rem_sh;
    logic [2*WIDTH:0]   mul_nx, div_nx;
    logic [2*WIDTH-1:0] prod;
    logic               geq;
    always_comb begin
        abs_a  = a[WIDTH-1] ? -a : a;
        abs_b  = b[WIDTH-1] ? -b : b;
        sum    = acc_q[2*WIDTH:WIDTH] + {1'b0, mag_q};
        mul_nx = acc_q[0] ? {sum, acc_q[WIDTH-1:0]} >> 1 : acc_q >> 1;
        rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        geq    = rem_sh >= {1'b0, mag_q};
        div_nx = {geq ? rem_sh - {1'b0, mag_q} : rem_sh, acc_q[WIDTH-2:0], geq};
        prod   = sign_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
        quot   = sign_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem    = rsign_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        state_d = state_q;
        acc_d   = acc_q;
        mag_d   = mag_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        sign_d  = sign_q;
        rsign_d = rsign_q;
        done_d  = 1'b0;
        div0_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (md_op == 2'b01) begin
                    acc_d   = {{(WIDTH+1){1'b0}}, abs_b};
                    mag_d   = abs_a;
                    div_d   = 1'b0;
                    sign_d  = a[WIDTH-1] ^ b[WIDTH-1];
                    cnt_d   = '0;
                    state_d = RUN;
                end else if (md_op == 2'b10) begin
                    if (b == '0) begin
                        done_d = 1'b1;
                        div0_d = 1'b1;
                    end else begin
                        acc_d   = {{(WIDTH+1){1'b0}}, abs_a};
                        mag_d   = abs_b;
                        div_d   = 1'b1;
                        sign_d  = a[WIDTH-1] ^ b[WIDTH-1];
                        rsign_d = a[WIDTH-1];
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                acc_d   = div_q ? div_nx : mul_nx;
                cnt_d   = cnt_q + CW'(1);
                state_d = (cnt_q == LAST) ? FIX : RUN;
            end
            FIX: begin
                hi_d    = div_q ? rem : prod[2*WIDTH-1:WIDTH];
                lo_d    = div_q ? quot : prod[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            mag_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            sign_q  <= 1'b0;
            rsign_q <= 1'b0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mag_q   <= mag_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            sign_q  <= sign_d;
            rsign_q <= rsign_d;
            done_q  <= done_d;
            div0_q  <= div0_d;
        end
    end
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = state_q != IDLE;
    assign done = done_q;
    assign div0 = div0_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed scoreboard bench for mult_div_unit
module tb_mult_div_unit;
    localparam int W = 32;
    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [1:0]   md_op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] hi, lo;
    logic         busy, done, div0;
    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         d0;
    } exp_t;
    exp_t         sb[$];
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    int           total = 0;
    int           bad = 0;
    always #5 clock = ~clock;
    mult_div_unit #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .md_op(md_op), .a(a), .b(b),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div0(div0)
    );
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask
    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy, p, q, r;
        exp_t   e;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (op == 2'b01) begin
            p = sx * sy;
            e = {p[63:32], p[31:0], 1'b0};
        end else if (y == '0) begin
            e = {m_hi, m_lo, 1'b1};
        end else begin
            q = sx / sy;
            r = sx % sy;
            e = {r[31:0], q[31:0], 1'b0};
        end
        return e;
    endfunction
    task automatic issue(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        sb.push_back(model(op, x, y));
        md_op = op;
        a = x;
        b = y;
        @(negedge clock);
        md_op = 2'b00;
    endtask
    task automatic collect(input string tag, input bit post);
        int   n;
        int   bc;
        exp_t e;
        n = 0;
        bc = int'(busy);
        while (!done && n < 40) begin
            @(negedge clock);
            n++;
            if (!done) bc += int'(busy);
        end
        chk({tag, "_done"}, 64'(done), 64'(1));
        if (sb.size() == 0) begin
            chk({tag, "_scoreboard"}, 64'(0), 64'(1));
        end else begin
            e = sb.pop_front();
            chk({tag, "_hi"}, 64'(hi), 64'(e.hi));
            chk({tag, "_lo"}, 64'(lo), 64'(e.lo));
            chk({tag, "_div0"}, 64'(div0), 64'(e.d0));
            chk({tag, "_latency"}, 64'(n), e.d0 ? 64'(0) : 64'(33));
            chk({tag, "_busy_cycles"}, 64'(bc), e.d0 ? 64'(0) : 64'(33));
            if (!e.d0) begin
                m_hi = e.hi;
                m_lo = e.lo;
            end
        end
        if (post) begin
            @(negedge clock);
            chk({tag, "_pulse"}, 64'({done, div0}), 64'(0));
        end
    endtask
    initial begin
        int dc;
        repeat (3) @(negedge clock);
        chk("reset_state", 64'({hi, lo, busy, done, div0}), 64'(0));
        reset = 1'b1;
        @(negedge clock);
        issue(2'b01, 32'd7, 32'hFFFF_FFFD);
        collect("mul_7_m3", 1'b1);
        issue(2'b10, -32'sd7, 32'd2);
        collect("div_m7_2", 1'b1);
        issue(2'b10, 32'd7, -32'sd2);
        collect("div_7_m2", 1'b1);
        issue(2'b10, 32'd5, 32'd0);
        collect("div_by_zero", 1'b1);
        md_op = 2'b11;
        a = 32'd9;
        b = 32'd3;
        @(negedge clock);
        md_op = 2'b00;
        chk("reserved_idle", 64'({busy, done, div0}), 64'(0));
        @(negedge clock);
        chk("reserved_hold", 64'({hi, lo}), {m_hi, m_lo});
        issue(2'b01, 32'h8000_0000, 32'h8000_0000);
        collect("mul_min_min", 1'b1);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        collect("div_overflow", 1'b1);
        for (int i = 0; i < 4; i++) begin
            issue((i % 2 == 0) ? 2'b01 : 2'b10, $urandom, $urandom | 32'h1);
            collect("random_op", 1'b1);
        end
        issue(2'b01, 32'h0001_2345, -32'sd2457);
        md_op = 2'b10;
        a = 32'd100;
        b = 32'd7;
        collect("b2b_mul", 1'b0);
        sb.push_back(model(2'b10, a, b));
        @(negedge clock);
        md_op = 2'b00;
        chk("b2b_accept", 64'(busy), 64'(1));
        collect("b2b_div", 1'b1);
        issue(2'b10, -32'sd100, 32'd7);
        void'(sb.pop_back());
        repeat (8) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        m_hi = '0;
        m_lo = '0;
        chk("abort_state", 64'({hi, lo, busy, done}), 64'(0));
        dc = 0;
        repeat (40) begin
            @(negedge clock);
            dc += int'(done);
        end
        chk("abort_no_done", 64'(dc), 64'(0));
        issue(2'b01, -32'sd12, -32'sd11);
        collect("mul_after_abort", 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
